// File: rtl/heap_pkg.sv
// Purpose: shared ordering helpers for the heap sorter and the streaming top-K selector.
// Latency: combinational functions only.
// Backpressure: not applicable.
// Contents: flag encodings, cell mode and FSM state enums, sentinel builder,
// and flag-aware cmp_lt/better. Entries are passed zero-extended to 64 bits,
// together with the real entry and key widths.
package heap_pkg;

  localparam logic [1:0] FLAG_NORMAL   = 2'b00;
  localparam logic [1:0] FLAG_MIN_SENT = 2'b01;
  localparam logic [1:0] FLAG_MAX_SENT = 2'b11;

  typedef enum logic [2:0] {
    CELL_HOLD,
    CELL_LOAD_NEW,
    CELL_LOAD_LEFT,
    CELL_SHIFT_RIGHT,
    CELL_CLEAR
  } cell_mode_e;

  typedef enum logic {
    ST_FILL,
    ST_DRAIN
  } state_e;

  function automatic logic [1:0] flag_of(input logic [63:0] e, input int dw);
    return 2'((e >> (dw - 2)) & 64'h3);
  endfunction

  function automatic logic [63:0] key_mask(input int kw);
    return (kw >= 64) ? '1 : ((64'd1 << kw) - 64'd1);
  endfunction

  // Position on the ascending axis: min-sentinel < any normal entry < max-sentinel.
  // The unused flag encoding 10 is ranked like a normal entry.
  function automatic logic [1:0] flag_rank(input logic [1:0] f);
    case (f)
      FLAG_MIN_SENT: return 2'd0;
      FLAG_MAX_SENT: return 2'd2;
      default:       return 2'd1;
    endcase
  endfunction

  // Strict ascending order; two sentinels of the same kind compare equal.
  function automatic logic cmp_lt(input logic [63:0] a, input logic [63:0] b,
                                  input int dw, input int kw);
    logic [1:0] ra;
    logic [1:0] rb;
    ra = flag_rank(flag_of(a, dw));
    rb = flag_rank(flag_of(b, dw));
    if (ra != rb) return ra < rb;
    return (ra == 2'd1) && ((a & key_mask(kw)) < (b & key_mask(kw)));
  endfunction

  // a ranks strictly ahead of b in drain order; equal keys are never better.
  function automatic logic better(input logic [63:0] a, input logic [63:0] b,
                                  input int dw, input int kw, input logic keep_max);
    return keep_max ? cmp_lt(b, a, dw, kw) : cmp_lt(a, b, dw, kw);
  endfunction

  // Worst possible entry for the mode: loses against every normal entry.
  function automatic logic [63:0] sentinel(input logic keep_max, input int dw, input int kw);
    logic [63:0] s;
    if (keep_max) begin
      s = 64'(FLAG_MIN_SENT) << (dw - 2);
    end else begin
      s = (64'(FLAG_MAX_SENT) << (dw - 2)) | key_mask(kw);
    end
    return s;
  endfunction

endpackage

// File: rtl/heap_topk_stream_cell.sv
// Purpose: one slot of the sorted insertion array (module topk_cell).
// Latency: register loads on the edge after mode is presented; new_better is combinational.
// Backpressure: none; the parent decides the mode each cycle.
// Ports: mode selects hold/load-new/load-left/shift-right/clear; new_data is the
// incoming entry, left_data the better neighbour, right_data the worse neighbour;
// data is the held entry; new_better = better(new_data, data).
module topk_cell
  import heap_pkg::*;
#(
  parameter int DW       = 32,
  parameter int KW       = 16,
  parameter int KEEP_MAX = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  cell_mode_e    mode,
  input  logic [DW-1:0] new_data,
  input  logic [DW-1:0] left_data,
  input  logic [DW-1:0] right_data,
  output logic [DW-1:0] data,
  output logic          new_better
);

  localparam logic [DW-1:0] SENT = DW'(sentinel(KEEP_MAX != 0, DW, KW));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= SENT;
    end else begin
      case (mode)
        CELL_LOAD_NEW:    data <= new_data;
        CELL_LOAD_LEFT:   data <= left_data;
        CELL_SHIFT_RIGHT: data <= right_data;
        CELL_CLEAR:       data <= SENT;
        default:          data <= data;
      endcase
    end
  end

  assign new_better = better(64'(new_data), 64'(data), DW, KW, KEEP_MAX != 0);

endmodule

// File: rtl/heap_topk_stream.sv
// Purpose: streaming top-K selector; keeps the DEPTH best entries, drains them best-first.
// Latency: insert visible 1 cycle after acceptance; first out_valid the cycle after flush.
// Backpressure: in_ready low while draining or in init; out_data held while out_valid & ~out_ready.
// Ports: clk/rstn; init synchronous clear; in_valid/in_ready/in_data input stream;
// flush starts a drain; out_valid/out_ready/out_data/out_last drain stream;
// count = entries held; drop pulses after a discard/eviction; drain_done pulses when a drain ends.
module heap_topk_stream
  import heap_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int KEY_WIDTH  = 16,
  parameter  int DEPTH      = 16,
  parameter  int KEEP_MAX   = 0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CW-1:0]         count,
  output logic                  drop,
  output logic                  drain_done
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] SENT = DW'(sentinel(KEEP_MAX != 0, DW, KEY_WIDTH));

  state_e          state;
  state_e          state_nxt;
  logic [DW-1:0]   cell_q [DEPTH];
  cell_mode_e      cell_mode [DEPTH];
  logic [DEPTH-1:0] new_better;
  logic [DEPTH-1:0] prev_better;
  logic            in_normal;
  logic            insert;
  logic            pop;
  logic            full;

  assign in_normal = (flag_of(64'(in_data), DW) == FLAG_NORMAL);
  assign full      = (count == CW'(DEPTH));
  assign insert    = in_valid & in_ready & in_normal;
  assign pop       = out_valid & out_ready & ~init;
  assign out_data  = cell_q[0];
  assign out_last  = out_valid & (count == CW'(1));

  // Cell i takes its left neighbour when the new entry outranks that neighbour,
  // so prev_better[i] is new_better[i-1] with a constant 0 feeding cell 0.
  assign prev_better = {new_better[DEPTH-2:0], 1'b0};

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_FILL: begin
        in_ready = ~init;
        if (flush) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = (count != '0);
        // Leave on the edge that removes the final entry, or at once if entered empty.
        if ((count == '0) || (pop && (count == CW'(1)))) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
    if (init) state_nxt = ST_FILL;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_mode[i] = CELL_HOLD;
      if (init) begin
        cell_mode[i] = CELL_CLEAR;
      end else if (pop) begin
        cell_mode[i] = CELL_SHIFT_RIGHT;
      end else if (insert) begin
        if (prev_better[i])     cell_mode[i] = CELL_LOAD_LEFT;
        else if (new_better[i]) cell_mode[i] = CELL_LOAD_NEW;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic [DW-1:0] left_d;
    logic [DW-1:0] right_d;
    if (g == 0) begin : g_first
      assign left_d = in_data;
    end else begin : g_mid_l
      assign left_d = cell_q[g-1];
    end
    if (g == DEPTH - 1) begin : g_last
      assign right_d = SENT;
    end else begin : g_mid_r
      assign right_d = cell_q[g+1];
    end
    topk_cell #(
      .DW      (DW),
      .KW      (KEY_WIDTH),
      .KEEP_MAX(KEEP_MAX)
    ) u_cell (
      .clk       (clk),
      .rstn      (rstn),
      .mode      (cell_mode[g]),
      .new_data  (in_data),
      .left_data (left_d),
      .right_data(right_d),
      .data      (cell_q[g]),
      .new_better(new_better[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_FILL;
      count      <= '0;
      drop       <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop       <= ~init & insert & full;
      drain_done <= ~init & (state == ST_DRAIN) & (state_nxt == ST_FILL);
      if (init) begin
        count <= '0;
      end else if (insert && !full) begin
        count <= count + CW'(1);
      end else if (pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_heap_topk_stream.sv
module tb_heap_topk_stream;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        init = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, out_last0, drop0, dd0;
  logic [31:0] out_data0;
  logic [2:0]  count0;
  logic        in_ready1, out_valid1, out_last1, drop1, dd1;
  logic [31:0] out_data1;
  logic [2:0]  count1;

  int n_chk = 0;
  int n_fail = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        stall0 = 1'b0, stall1 = 1'b0;
  logic [31:0] hold0 = '0, hold1 = '0;

  always #5 clk = ~clk;

  heap_topk_stream #(.DATA_WIDTH(32), .KEY_WIDTH(16), .DEPTH(4), .KEEP_MAX(0)) dut0 (
    .clk(clk), .rstn(rstn), .init(init), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_last(out_last0), .count(count0), .drop(drop0),
    .drain_done(dd0));

  heap_topk_stream #(.DATA_WIDTH(32), .KEY_WIDTH(16), .DEPTH(4), .KEEP_MAX(1)) dut1 (
    .clk(clk), .rstn(rstn), .init(init), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_last(out_last1), .count(count1), .drop(drop1),
    .drain_done(dd1));

  function automatic logic [31:0] mk(input logic [1:0] f, input logic [13:0] p, input logic [15:0] k);
    return {f, p, k};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp0(input logic [15:0] k, input logic [13:0] p, input logic last);
    q0.push_back({last, mk(2'b00, p, k)});
  endtask

  task automatic exp1(input logic [15:0] k, input logic [13:0] p, input logic last);
    q1.push_back({last, mk(2'b00, p, k)});
  endtask

  // Output monitor for one instance: stability under stall, in_ready low while
  // draining, and every handshake compared against the head of its queue.
  task automatic mon(input int w, input logic v, input logic [31:0] d, input logic l,
                     input logic ir);
    logic [32:0] e;
    logic        st;
    logic [31:0] hd;
    st = (w == 0) ? stall0 : stall1;
    hd = (w == 0) ? hold0 : hold1;
    if (st) chk($sformatf("hold_stable%0d", w), {31'd0, v, d}, {31'd0, 1'b1, hd});
    if (v) begin
      chk($sformatf("in_ready_drain%0d", w), 64'(ir), 64'd0);
      if (out_ready) begin
        if (((w == 0) ? q0.size() : q1.size()) == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat%0d: got unexpected beat %0h, expected no beat", w, d);
        end else begin
          if (w == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("beat%0d", w), 64'({l, d}), 64'(e));
        end
      end
    end
    if (w == 0) begin
      stall0 = v & ~out_ready & ~init;
      hold0  = d;
    end else begin
      stall1 = v & ~out_ready & ~init;
      hold1  = d;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      mon(0, out_valid0, out_data0, out_last0, in_ready0);
      mon(1, out_valid1, out_data1, out_last1, in_ready1);
    end else begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic ed0, input logic ed1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drop0", 64'(drop0), 64'(ed0));
    chk("drop1", 64'(drop1), 64'(ed1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain_all(input logic [3:0] pat, input logic hold_in);
    logic seen;
    seen     = 1'b0;
    in_valid = hold_in;
    in_data  = mk(2'b00, 14'h55, 16'd7);
    for (int i = 0; i < 64 && !seen; i++) begin
      out_ready = pat[i % 4];
      @(negedge clk);
      if (out_valid0 && out_ready && out_last0) seen = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drain_finished", 64'(seen), 64'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 10 && !dd0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_done0", 64'(dd0), 64'd1);
    chk("drain_done1", 64'(dd1), 64'd1);
    @(posedge clk); #1;
    chk("drain_done0_pulse", 64'(dd0), 64'd0);
  endtask

  logic [15:0] t1_keys [6] = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd5, 16'd2};
  logic        t1_drop [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] t6_keys [4] = '{16'd10, 16'd20, 16'd30, 16'd40};

  initial begin
    #12 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_count0", 64'(count0), 64'd0);
    chk("rst_count1", 64'(count1), 64'd0);
    chk("rst_in_ready0", 64'(in_ready0), 64'd1);
    chk("rst_out_valid0", 64'(out_valid0), 64'd0);
    chk("rst_drop0", 64'(drop0), 64'd0);
    chk("rst_drain_done0", 64'(dd0), 64'd0);

    // Keys 9,3,7,1,5,2 into both modes.
    for (int i = 0; i < 6; i++) send(mk(2'b00, 14'd0, t1_keys[i]), t1_drop[i], t1_drop[i]);
    chk("t1_count0_full", 64'(count0), 64'd4);
    chk("t1_count1_full", 64'(count1), 64'd4);
    exp0(1, 0, 0); exp0(2, 0, 0); exp0(3, 0, 0); exp0(5, 0, 1);
    exp1(9, 0, 0); exp1(7, 0, 0); exp1(5, 0, 0); exp1(3, 0, 1);
    do_flush();
    chk("t1_first_valid", 64'(out_valid0), 64'd1);
    drain_all(4'b1111, 1'b0);
    wait_done();
    chk("t1_count0_empty", 64'(count0), 64'd0);
    chk("t1_count1_empty", 64'(count1), 64'd0);

    // Backpressure with in_valid held during the drain.
    send(mk(2'b00, 14'd0, 16'd8), 1'b0, 1'b0);
    send(mk(2'b00, 14'd0, 16'd6), 1'b0, 1'b0);
    send(mk(2'b00, 14'd0, 16'd4), 1'b0, 1'b0);
    send(mk(2'b00, 14'd0, 16'd2), 1'b0, 1'b0);
    exp0(2, 0, 0); exp0(4, 0, 0); exp0(6, 0, 0); exp0(8, 0, 1);
    exp1(8, 0, 0); exp1(6, 0, 0); exp1(4, 0, 0); exp1(2, 0, 1);
    do_flush();
    drain_all(4'b1001, 1'b1);
    wait_done();
    chk("t3_count0_after", 64'(count0), 64'd0);

    // Equal keys keep arrival order.
    send(mk(2'b00, 14'h0A, 16'd4), 1'b0, 1'b0);
    send(mk(2'b00, 14'h0B, 16'd4), 1'b0, 1'b0);
    exp0(4, 14'h0A, 0); exp0(4, 14'h0B, 1);
    exp1(4, 14'h0A, 0); exp1(4, 14'h0B, 1);
    do_flush();
    drain_all(4'b1111, 1'b0);
    wait_done();

    // Empty flush, then sentinel-flagged inputs.
    do_flush();
    chk("t5_no_valid0", 64'(out_valid0), 64'd0);
    chk("t5_no_valid1", 64'(out_valid1), 64'd0);
    wait_done();
    send(mk(2'b01, 14'd0, 16'd3), 1'b0, 1'b0);
    send(mk(2'b11, 14'd0, 16'd3), 1'b0, 1'b0);
    chk("t5_count0", 64'(count0), 64'd0);
    chk("t5_count1", 64'(count1), 64'd0);

    // init after two of four beats.
    for (int i = 0; i < 4; i++) send(mk(2'b00, 14'd0, t6_keys[i]), 1'b0, 1'b0);
    exp0(10, 0, 0); exp0(20, 0, 0);
    exp1(40, 0, 0); exp1(30, 0, 0);
    do_flush();
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t6_count0_mid", 64'(count0), 64'd2);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    chk("t6_init_valid0", 64'(out_valid0), 64'd0);
    chk("t6_init_count0", 64'(count0), 64'd0);
    chk("t6_init_valid1", 64'(out_valid1), 64'd0);
    chk("t6_init_count1", 64'(count1), 64'd0);
    chk("t6_init_no_done", 64'(dd0), 64'd0);
    @(posedge clk); #1;
    chk("t6_init_no_done_late", 64'(dd0), 64'd0);
    do_flush();
    chk("t6_empty_valid0", 64'(out_valid0), 64'd0);
    wait_done();

    // Same again with an asynchronous reset pulse.
    for (int i = 0; i < 4; i++) send(mk(2'b00, 14'd0, t6_keys[i]), 1'b0, 1'b0);
    exp0(10, 0, 0); exp0(20, 0, 0);
    exp1(40, 0, 0); exp1(30, 0, 0);
    do_flush();
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid0", 64'(out_valid0), 64'd0);
    chk("t6_rst_count0", 64'(count0), 64'd0);
    chk("t6_rst_valid1", 64'(out_valid1), 64'd0);
    chk("t6_rst_count1", 64'(count1), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_in_ready0", 64'(in_ready0), 64'd1);
    do_flush();
    chk("t6_rst_empty_valid0", 64'(out_valid0), 64'd0);
    wait_done();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
